// File: rtl/t07_mmio_pkg.sv
// Shared types and default region map for the MMIO router.
package t07_mmio_pkg;

   localparam int MAX_CH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } mmio_state_t;

   // Default four-region map: ch0 ext regs, ch1 data mem, ch2 SPI TFT, ch3 instr mem.
   // Packed index [0] is the rightmost element of each concatenation.
   localparam logic [3:0][31:0] DEF_REGION_BASE  = {32'h0000_0000, 32'h0000_0700,
                                                    32'h0000_0500, 32'h0000_0400};
   localparam logic [3:0][31:0] DEF_REGION_LIMIT = {32'h0000_0400, 32'h0000_0800,
                                                    32'h0000_0700, 32'h0000_0500};
   localparam logic [3:0]       DEF_RD_OK        = 4'b1011;
   localparam logic [3:0]       DEF_WR_OK        = 4'b0110;

endpackage

// File: rtl/t07_mmio_router_decoder.sv
// Combinational priority decoder: first (lowest-index) region containing addr wins.
module t07_mmio_decoder
   import t07_mmio_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int N_CH   = 4,
   parameter logic [N_CH-1:0][ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
   parameter logic [N_CH-1:0][ADDR_W-1:0] REGION_LIMIT = DEF_REGION_LIMIT
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [N_CH-1:0]   sel,
   output logic [ADDR_W-1:0] offset
);

   // Scan from the highest index down so the lowest matching index is written last.
   always_comb begin
      hit    = 1'b0;
      sel    = '0;
      offset = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (addr >= REGION_BASE[i] && addr < REGION_LIMIT[i]) begin
            hit    = 1'b1;
            sel    = '0;
            sel[i] = 1'b1;
            offset = addr - REGION_BASE[i];
         end
      end
   end

endmodule

// File: rtl/t07_mmio_router.sv
// Registered MMIO router: decodes one CPU request, runs a req/ack handshake with
// the selected channel and returns done/err with registered read data.
// Handshake: ch_req[sel] stays high through ISSUE until ch_ack[sel] is seen high
// at a clock edge; acks on other channels are ignored, no ack for TIMEOUT cycles
// ends the request with cpu_err.
module t07_mmio_router
   import t07_mmio_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int N_CH   = 4,
   parameter logic [N_CH-1:0][ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
   parameter logic [N_CH-1:0][ADDR_W-1:0] REGION_LIMIT = DEF_REGION_LIMIT,
   parameter logic [N_CH-1:0]             RD_OK        = DEF_RD_OK,
   parameter logic [N_CH-1:0]             WR_OK        = DEF_WR_OK,
   parameter int TIMEOUT = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cpu_req,
   input  logic                         cpu_we,
   input  logic [ADDR_W-1:0]            cpu_addr,
   input  logic [DATA_W-1:0]            cpu_wdata,
   output logic                         cpu_busy,
   output logic                         cpu_done,
   output logic                         cpu_err,
   output logic [DATA_W-1:0]            cpu_rdata,
   output logic [N_CH-1:0]              ch_req,
   output logic                         ch_we,
   output logic [ADDR_W-1:0]            ch_addr,
   output logic [DATA_W-1:0]            ch_wdata,
   input  logic [N_CH-1:0]              ch_ack,
   input  logic [N_CH-1:0][DATA_W-1:0]  ch_rdata,
   output mmio_state_t                  fsm_state
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   mmio_state_t       state;
   logic [N_CH-1:0]   sel_q;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;

   logic              dec_hit;
   logic [N_CH-1:0]   dec_sel;
   logic [ADDR_W-1:0] dec_offset;
   logic              permitted;
   logic              ack_hit;
   logic [DATA_W-1:0] sel_rdata;

   t07_mmio_decoder #(
      .ADDR_W       (ADDR_W),
      .N_CH         (N_CH),
      .REGION_BASE  (REGION_BASE),
      .REGION_LIMIT (REGION_LIMIT)
   ) u_decoder (
      .addr   (cpu_addr),
      .hit    (dec_hit),
      .sel    (dec_sel),
      .offset (dec_offset)
   );

   assign permitted = dec_hit && (|(dec_sel & (cpu_we ? WR_OK : RD_OK)));
   assign cnt_next  = cnt + CNT_W'(1);
   assign fsm_state = state;

   // Only the selected channel's ack and read data are looked at.
   always_comb begin
      ack_hit   = |(ch_ack & sel_q);
      sel_rdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_q[i]) sel_rdata = ch_rdata[i];
      end
   end

   // Transaction FSM with all CPU- and channel-side outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel_q     <= '0;
         cnt       <= '0;
         cpu_busy  <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         ch_req    <= '0;
         ch_we     <= 1'b0;
         ch_addr   <= '0;
         ch_wdata  <= '0;
      end else begin
         cpu_done <= 1'b0;
         cpu_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  sel_q    <= dec_sel;
                  cnt      <= '0;
                  cpu_busy <= 1'b1;
                  if (permitted) begin
                     state    <= ISSUE;
                     ch_req   <= dec_sel;
                     ch_we    <= cpu_we;
                     ch_addr  <= dec_offset;
                     ch_wdata <= cpu_wdata;
                  end else begin
                     state     <= ERR;
                     cpu_err   <= 1'b1;
                     cpu_rdata <= '0;
                  end
               end
            end
            ISSUE: begin
               // Ack is checked before the timeout so a coincident ack completes.
               if (ack_hit) begin
                  state    <= DONE;
                  cpu_done <= 1'b1;
                  if (!ch_we) cpu_rdata <= sel_rdata;
                  ch_req   <= '0;
                  ch_we    <= 1'b0;
                  ch_addr  <= '0;
                  ch_wdata <= '0;
               end else if (cnt_next == TO_VAL) begin
                  state     <= ERR;
                  cpu_err   <= 1'b1;
                  cpu_rdata <= '0;
                  ch_req    <= '0;
                  ch_we     <= 1'b0;
                  ch_addr   <= '0;
                  ch_wdata  <= '0;
               end else begin
                  cnt <= cnt_next;
               end
            end
            DONE, ERR: begin
               state    <= IDLE;
               cpu_busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               cpu_busy <= 1'b0;
               ch_req   <= '0;
               ch_we    <= 1'b0;
               ch_addr  <= '0;
               ch_wdata <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/t07_mmio_router.md
# t07_mmio_router

Parametrised, registered successor to the team's combinational MMIO address decoder. It accepts one CPU memory request at a time and decodes the address against a table of `N_CH` regions. It drives a req/ack handshake toward the selected peripheral channel (external registers, data memory, SPI TFT, instruction memory, …) and returns a registered response with done/error status. It sits between the CPU memory handler and the peripheral bus, and adds per-region access permissions, unmapped-address errors and an ack timeout.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `N_CH`, 4, number of peripheral channels/regions (1..8).
- `REGION_BASE`, `[N_CH][ADDR_W]`, inclusive base per channel (default from package: 0x400, 0x500, 0x700, 0x000).
- `REGION_LIMIT`, `[N_CH][ADDR_W]`, exclusive limit per channel (default: 0x500, 0x700, 0x800, 0x400).
- `RD_OK`, `[N_CH]`, read permitted per channel (default 4'b1011).
- `WR_OK`, `[N_CH]`, write permitted per channel (default 4'b0110).
- `TIMEOUT`, 255, maximum cycles waiting for ack (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_req`  in  1  request strobe, sampled only in IDLE.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  `ADDR_W`  byte address.
- `cpu_wdata`  in  `DATA_W`  write data.
- `cpu_busy`  out  1  high whenever FSM ≠ IDLE.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  one-cycle error pulse (unmapped, not permitted, timeout).
- `cpu_rdata`  out  `DATA_W`  registered read data, valid with `cpu_done`, held until next accept.
- `ch_req`  out  `N_CH`  one-hot request to the selected channel.
- `ch_we`  out  1  write flag for the active request.
- `ch_addr`  out  `ADDR_W`  offset = `cpu_addr − REGION_BASE[sel]`.
- `ch_wdata`  out  `DATA_W`  write data for the active request.
- `ch_ack`  in  `N_CH`  per-channel acknowledge.
- `ch_rdata`  in  `[N_CH][DATA_W]`  per-channel read data, valid with ack.

## Operation
- Region `i` matches when `REGION_BASE[i] ≤ addr < REGION_LIMIT[i]`. Overlaps resolve to the lowest index. No match = unmapped.
- A request is permitted when the region matches and `RD_OK[i]` (read) or `WR_OK[i]` (write) is set.
- States: IDLE, ISSUE, DONE, ERR.
- IDLE: on `cpu_req`, register `we`, `addr`, `wdata` and `sel`, and clear the timeout counter.
  - Permitted request → ISSUE.
  - Unmapped or not permitted → ERR; no `ch_req` is issued.
- ISSUE:
  - `ch_req[sel]` is held high.
  - Only `ch_ack[sel]` is honoured; acks on other channels are ignored.
  - On ack → DONE, and for reads `cpu_rdata ← ch_rdata[sel]`.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT` → ERR.
- DONE: assert `cpu_done`, then → IDLE.
- ERR: assert `cpu_err`, `cpu_rdata ← 0`, then → IDLE.
- `cpu_req` in any state other than IDLE is ignored, not queued.
- Writes leave `cpu_rdata` unchanged.

## Timing
- Reset values: FSM = IDLE; all outputs 0, including `cpu_rdata` and the `ch_*` outputs.
- Reset mid-transaction drops `ch_req` immediately (asynchronously). No done or err pulse follows.
- Accept at edge 0 → `ch_req` and `cpu_busy` high from cycle 1.
- Ack sampled at edge k → `ch_req` low and `cpu_done` high in cycle k+1 → IDLE at k+2.
  - Minimum request-to-done latency: 2 cycles.
  - Back-to-back accept is possible at edge k+2.
- Error path: `cpu_err` in cycle 1, IDLE in cycle 2.
- Timeout: ack absent for `TIMEOUT` ISSUE cycles → `cpu_err`.
- Ack arriving in the same cycle the counter hits `TIMEOUT`: ack wins, and the request completes as DONE.
- `ch_addr`, `ch_we` and `ch_wdata` are registered and stable for the whole of ISSUE. They are 0 in all other states.
- The counter is wide enough for `TIMEOUT`, with no wrap.

## Structure
- Package `t07_mmio_pkg` holds:
  - the state enum `mmio_state_t`;
  - the default region base/limit/permission constants;
  - `MAX_CH` = 8.
- Sub-module `t07_mmio_decoder`: combinational priority match of an address against the region table. Outputs `hit`, one-hot `sel`, and `offset`.

## Test plan
- Read at 0x520 (ch1), ack after 3 cycles with data 0xDEADBEEF → `ch_req` = 0010 with `ch_addr` = 0x20; `cpu_done` in cycle 5; `cpu_rdata` = 0xDEADBEEF.
- Write 0x1234 to 0x710 (ch2), ack immediately → `ch_wdata` = 0x1234 with `ch_addr` = 0x10; `cpu_done` in cycle 2; `cpu_rdata` unchanged.
- Write to 0x410 (ch0 is read-only) and read from 0x900 (unmapped) → `cpu_err` in cycle 1 for each; no `ch_req` ever asserted.
- Read at 0x100 (ch3) with no ack, `TIMEOUT` = 4 → `cpu_err` after 4 ISSUE cycles; `ch_req` drops.
- Ack coincident with the timeout cycle → `cpu_done`, no `cpu_err`.
- Boundaries: 0x500 → ch1, 0x4FF → ch0.
- `rst` asserted mid-ISSUE → `ch_req` and `cpu_busy` drop the same cycle; no pulse follows.
- `cpu_req` held high while busy → exactly one transaction occurs.
